// File: rtl/kei_i2c_bus_resolver_pkg.sv
// Shared types and constants for the I2C bus resolver block.
package kei_i2c_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    localparam int BIT_CNT_W    = 4;
    localparam int ACK_BIT_IDX  = 8;   // bit_cnt value on the 9th (ack) clock
    localparam int TMO_CNT_W    = 16;

    localparam int DEF_N_AGENTS = 2;
    localparam int DEF_FILT_CYC = 3;
    localparam int DEF_TMO_CYC  = 1024;

endpackage

// File: rtl/kei_i2c_bus_resolver_if.sv
// Agent/pad inputs and observed-bus outputs of the I2C bus resolver.
interface kei_i2c_bus_resolver_if
#(
    parameter int N_AGENTS = kei_i2c_pkg::DEF_N_AGENTS
);
    import kei_i2c_pkg::*;

    logic [N_AGENTS-1:0]  scl_drv;
    logic [N_AGENTS-1:0]  sda_drv;
    logic [N_AGENTS-1:0]  arb_en;
    logic                 scl_in;
    logic                 sda_in;
    logic                 arb_clr;

    logic                 scl_line;
    logic                 sda_line;
    logic                 scl_filt;
    logic                 sda_filt;
    logic                 start_p;
    logic                 rstart_p;
    logic                 stop_p;
    logic                 bus_busy;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 ack_p;
    logic                 nack_p;
    logic [N_AGENTS-1:0]  arb_lost;
    logic                 tmo_p;

    // Side that drives the agents and pads.
    modport master (
        output scl_drv, sda_drv, arb_en, scl_in, sda_in, arb_clr,
        input  scl_line, sda_line, scl_filt, sda_filt, start_p, rstart_p, stop_p,
               bus_busy, bit_cnt, ack_p, nack_p, arb_lost, tmo_p
    );

    // Resolver side.
    modport slave (
        input  scl_drv, sda_drv, arb_en, scl_in, sda_in, arb_clr,
        output scl_line, sda_line, scl_filt, sda_filt, start_p, rstart_p, stop_p,
               bus_busy, bit_cnt, ack_p, nack_p, arb_lost, tmo_p
    );

endinterface

// File: rtl/kei_i2c_bus_resolver_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised level after it has differed for FILT_CYC cycles.
module kei_i2c_line_filter
#(
    parameter int FILT_CYC = kei_i2c_pkg::DEF_FILT_CYC
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic filt_o
);
    import kei_i2c_pkg::*;

    localparam logic [3:0] CNT_LAST = 4'(FILT_CYC - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic       filt_q, filt_d;

    // Synchroniser; resets to the released (high) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], line_i};
    end

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) filt_d = sync_q[1];
            else                   cnt_d  = cnt_q + 4'd1;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/kei_i2c_bus_resolver.sv
// Wired-AND resolution of on-chip open-drain agents with the pads, plus a
// filtered bus monitor: START/STOP, bit counting, ack, arbitration, timeout.
module kei_i2c_bus_resolver
#(
    parameter int N_AGENTS = kei_i2c_pkg::DEF_N_AGENTS,
    parameter int FILT_CYC = kei_i2c_pkg::DEF_FILT_CYC,
    parameter int TMO_CYC  = kei_i2c_pkg::DEF_TMO_CYC
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    kei_i2c_bus_resolver_if.slave  bus
);
    import kei_i2c_pkg::*;

    // Cycles after reset before a filtered edge may be believed: enough for a
    // pad level present at reset release to propagate through the filters
    // and be swallowed by the edge detector instead of looking like a START.
    localparam int                   SETTLE   = FILT_CYC + 3;
    localparam logic [4:0]           SETTLE_V = 5'(SETTLE);
    localparam logic [BIT_CNT_W-1:0] BC_LAST  = BIT_CNT_W'(ACK_BIT_IDX);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_CYC);
    localparam logic [TMO_CNT_W-1:0] TMO_PRE  = TMO_CNT_W'(TMO_CYC - 1);

    logic scl_line, sda_line, scl_filt, sda_filt;

    bus_state_e           state_q, state_d;
    logic                 scl_prev_q, sda_prev_q;
    logic [4:0]           settle_q, settle_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [N_AGENTS-1:0]  arb_lost_q, arb_lost_d, arb_set;
    logic start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
    logic ack_q, ack_d, nack_q, nack_d, tmo_q, tmo_d;
    logic armed, sda_fall, sda_rise, scl_rise;

    assign scl_line = bus.scl_in & ~(|bus.scl_drv);
    assign sda_line = bus.sda_in & ~(|bus.sda_drv);

    kei_i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line_i(scl_line), .filt_o(scl_filt)
    );
    kei_i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line_i(sda_line), .filt_o(sda_filt)
    );

    assign armed    = (settle_q == SETTLE_V);
    assign sda_fall =  sda_prev_q & ~sda_filt;
    assign sda_rise = ~sda_prev_q &  sda_filt;
    assign scl_rise = ~scl_prev_q &  scl_filt;

    // Next state: bus conditions are judged against the previous SCL level so
    // that coincident SCL/SDA edges resolve deterministically.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        settle_d  = armed ? settle_q : settle_q + 5'd1;
        tmo_cnt_d = tmo_cnt_q;
        arb_set   = '0;
        start_d   = 1'b0;
        rstart_d  = 1'b0;
        stop_d    = 1'b0;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        tmo_d     = 1'b0;

        if (armed) begin
            if (scl_prev_q && sda_fall) begin
                if (state_q == ST_BUSY) rstart_d = 1'b1;
                else                    start_d  = 1'b1;
                state_d   = ST_BUSY;
                bit_cnt_d = '0;
            end else if (scl_prev_q && sda_rise && state_q == ST_BUSY) begin
                stop_d    = 1'b1;
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end else if (state_q == ST_BUSY && scl_rise) begin
                if (bit_cnt_q == BC_LAST) begin
                    ack_d     = ~sda_filt;
                    nack_d    =  sda_filt;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // A transmitter that released SDA but sees it low lost.
                    arb_set   = bus.arb_en & ~bus.sda_drv & {N_AGENTS{~sda_filt}};
                end
            end
        end

        // A new loss wins over a same-cycle clear; STOP wipes everything.
        if (stop_d) arb_lost_d = '0;
        else        arb_lost_d = (bus.arb_clr ? '0 : arb_lost_q) | arb_set;

        // SCL-low timeout: pulse on reaching the limit, then saturate.
        if (state_q == ST_BUSY && !scl_filt) begin
            if (tmo_cnt_q != TMO_LAST) begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                tmo_d     = (tmo_cnt_q == TMO_PRE);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            settle_q   <= '0;
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            arb_lost_q <= '0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_prev_q <= scl_filt;
            sda_prev_q <= sda_filt;
            settle_q   <= settle_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            arb_lost_q <= arb_lost_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.scl_line = scl_line;
    assign bus.sda_line = sda_line;
    assign bus.scl_filt = scl_filt;
    assign bus.sda_filt = sda_filt;
    assign bus.start_p  = start_q;
    assign bus.rstart_p = rstart_q;
    assign bus.stop_p   = stop_q;
    assign bus.bus_busy = (state_q == ST_BUSY);
    assign bus.bit_cnt  = bit_cnt_q;
    assign bus.ack_p    = ack_q;
    assign bus.nack_p   = nack_q;
    assign bus.arb_lost = arb_lost_q;
    assign bus.tmo_p    = tmo_q;

endmodule

// File: tb/tb_kei_i2c_bus_resolver.sv
// Bench for the I2C bus resolver: directed I2C traffic plus random pad/agent
// activity, compared every cycle against a history-based reference model.
module tb_kei_i2c_bus_resolver;

    localparam int N   = 2;
    localparam int F   = 3;
    localparam int TMO = 16;
    localparam int H   = 6;   // half-phase length of directed I2C traffic

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kei_i2c_bus_resolver_if #(.N_AGENTS(N)) bus();

    kei_i2c_bus_resolver #(.N_AGENTS(N), .FILT_CYC(F), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Line samples seen at each clock edge; the filtered level flips once the
    // F samples that are 2..F+1 edges old all disagree with it.
    bit       q_s[$], q_d[$];
    bit       mf_s = 1, mf_d = 1, mp_s = 1, mp_d = 1;
    bit       m_busy = 0;
    int       m_bc = 0;
    int       m_tcnt = 0;
    int       n_edges = 0;
    bit       m_start = 0, m_rstart = 0, m_stop = 0, m_ack = 0, m_nack = 0, m_tmo = 0;
    bit [N-1:0] m_arb = '0;

    function automatic bit new_filt(input bit cur, input bit hist[$]);
        for (int j = 0; j < F; j++)
            if (hist[hist.size() - 3 - j] == cur) return cur;
        return !cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit nfs, nfd, was_busy;
        bit [N-1:0] lost;
        if (!rst_n) begin
            q_s = {}; q_d = {};
            for (int j = 0; j < F + 2; j++) begin q_s.push_back(1'b1); q_d.push_back(1'b1); end
            mf_s = 1; mf_d = 1; mp_s = 1; mp_d = 1;
            m_busy = 0; m_bc = 0; m_tcnt = 0; n_edges = 0; m_arb = '0;
            m_start = 0; m_rstart = 0; m_stop = 0; m_ack = 0; m_nack = 0; m_tmo = 0;
        end else begin
            n_edges++;
            q_s.push_back(bus.scl_in & ~(|bus.scl_drv));
            q_d.push_back(bus.sda_in & ~(|bus.sda_drv));
            while (q_s.size() > F + 3) begin void'(q_s.pop_front()); void'(q_d.pop_front()); end
            nfs = new_filt(mf_s, q_s);
            nfd = new_filt(mf_d, q_d);
            m_start = 0; m_rstart = 0; m_stop = 0; m_ack = 0; m_nack = 0; m_tmo = 0;
            lost = '0;
            was_busy = m_busy;
            // Nothing seen through the filters in the first F+3 clocks counts.
            if (n_edges >= F + 4) begin
                if (mp_s && mp_d && !mf_d) begin
                    if (m_busy) m_rstart = 1; else m_start = 1;
                    m_busy = 1; m_bc = 0;
                end else if (mp_s && !mp_d && mf_d && m_busy) begin
                    m_stop = 1; m_busy = 0; m_bc = 0;
                end else if (m_busy && !mp_s && mf_s) begin
                    if (m_bc == 8) begin
                        m_ack = !mf_d; m_nack = mf_d; m_bc = 0;
                    end else begin
                        if (!mf_d) lost = bus.arb_en & ~bus.sda_drv;
                        m_bc++;
                    end
                end
            end
            if (m_stop) m_arb = '0;
            else        m_arb = (bus.arb_clr ? '0 : m_arb) | lost;
            if (was_busy && !mf_s) begin
                m_tcnt++;
                m_tmo = (m_tcnt == TMO);
            end else begin
                m_tcnt = 0;
            end
            mp_s = mf_s; mp_d = mf_d; mf_s = nfs; mf_d = nfd;
        end
    end

    // ---------------- compare + event monitor ----------------
    int n_start = 0, n_stop = 0, n_ack = 0, n_nack = 0, n_tmo = 0, max_bc = 0;
    bit sda_low_seen = 0;

    always @(negedge clk) begin
        chk("scl_line", bus.scl_line, bus.scl_in & ~(|bus.scl_drv));
        chk("sda_line", bus.sda_line, bus.sda_in & ~(|bus.sda_drv));
        chk("scl_filt", bus.scl_filt, mf_s);
        chk("sda_filt", bus.sda_filt, mf_d);
        chk("start_p",  bus.start_p,  m_start);
        chk("rstart_p", bus.rstart_p, m_rstart);
        chk("stop_p",   bus.stop_p,   m_stop);
        chk("bus_busy", bus.bus_busy, m_busy);
        chk("bit_cnt",  bus.bit_cnt,  m_bc);
        chk("ack_p",    bus.ack_p,    m_ack);
        chk("nack_p",   bus.nack_p,   m_nack);
        chk("arb_lost", bus.arb_lost, m_arb);
        chk("tmo_p",    bus.tmo_p,    m_tmo);
        if (bus.start_p) n_start++;
        if (bus.stop_p)  n_stop++;
        if (bus.ack_p)   n_ack++;
        if (bus.nack_p)  n_nack++;
        if (bus.tmo_p)   n_tmo++;
        if (int'(bus.bit_cnt) > max_bc) max_bc = int'(bus.bit_cnt);
        if (!bus.sda_filt) sda_low_seen = 1;
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic i2c_bit(input bit b);
        bus.scl_in = 0; cyc(H);
        bus.sda_in = b; cyc(H);
        bus.scl_in = 1; cyc(H);
    endtask

    task automatic send_byte(input bit [7:0] v, input bit ackb);
        for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
        i2c_bit(ackb);
    endtask

    task automatic start_cond();
        bus.sda_in = 0; cyc(H + 2);
    endtask

    task automatic stop_cond();
        bus.scl_in = 0; cyc(H);
        bus.sda_in = 0; cyc(H);
        bus.scl_in = 1; cyc(H);
        bus.sda_in = 1; cyc(H + 2);
    endtask

    initial begin
        int s0, k0, a0, n0, t0;
        bit [7:0] ag0, ag1;
        bus.scl_drv = '0; bus.sda_drv = '0; bus.arb_en = '0; bus.arb_clr = 0;
        bus.scl_in = 1; bus.sda_in = 1;
        cyc(3);
        chk("rst_scl_filt", bus.scl_filt, 1);
        chk("rst_sda_filt", bus.sda_filt, 1);
        chk("rst_busy",     bus.bus_busy, 0);
        chk("rst_bit_cnt",  bus.bit_cnt,  0);
        chk("rst_arb_lost", bus.arb_lost, 0);
        rst_n = 1;
        cyc(20);

        // START latency: filtered edge after 2+F clocks, pulse one clock later.
        s0 = n_start;
        bus.sda_in = 0;
        cyc(5);  chk("start_not_yet", bus.start_p, 0);
        cyc(1);  chk("start_at_6", bus.start_p, 1);
                 chk("busy_after_start", bus.bus_busy, 1);
        cyc(1);  chk("start_single", n_start - s0, 1);

        // 0xA5 with ack, then with nack.
        a0 = n_ack; n0 = n_nack; max_bc = 0;
        send_byte(8'hA5, 1'b0);
        cyc(2);
        chk("ack_once", n_ack - a0, 1);
        chk("no_nack", n_nack - n0, 0);
        chk("bit_cnt_max", max_bc, 8);
        chk("bit_cnt_wrap", bus.bit_cnt, 0);
        send_byte(8'hA5, 1'b1);
        cyc(2);
        chk("nack_once", n_nack - n0, 1);
        k0 = n_stop;
        stop_cond();
        chk("stop_once", n_stop - k0, 1);
        chk("idle_after_stop", bus.bus_busy, 0);

        // Two-clock SDA glitch with SCL high is filtered away.
        cyc(10);
        s0 = n_start; sda_low_seen = 0;
        bus.sda_in = 0; cyc(2); bus.sda_in = 1; cyc(12);
        chk("glitch_no_start", n_start - s0, 0);
        chk("glitch_filt_high", sda_low_seen, 0);

        // Arbitration: agent0 releases at bit index 3 while agent1 pulls low.
        start_cond();
        bus.arb_en = 2'b11;
        ag0 = 8'b0001_0000; ag1 = 8'b0000_0000;
        for (int i = 7; i >= 0; i--) begin
            bus.scl_in = 0; cyc(H);
            bus.sda_drv = {~ag1[i], ~ag0[i]}; cyc(H);
            bus.scl_in = 1; cyc(H);
        end
        bus.scl_in = 0; cyc(H); bus.sda_drv = '0; cyc(H); bus.scl_in = 1; cyc(H);
        chk("arb_lost_a0", bus.arb_lost, 2'b01);
        bus.arb_en = '0;
        stop_cond();
        chk("arb_cleared_stop", bus.arb_lost, 2'b00);

        // SCL held low for 40 clocks in BUSY: one timeout pulse.
        start_cond();
        t0 = n_tmo;
        bus.scl_in = 0; cyc(40);
        chk("tmo_once", n_tmo - t0, 1);
        chk("tmo_keeps_busy", bus.bus_busy, 1);
        bus.scl_in = 1; cyc(H);
        stop_cond();

        // Reset mid-byte, release with SCL high / SDA low, then STOP.
        start_cond();
        i2c_bit(1'b1); i2c_bit(1'b0);
        bus.scl_in = 0; cyc(3);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_busy",     bus.bus_busy, 0);
        chk("mid_rst_bit_cnt",  bus.bit_cnt,  0);
        chk("mid_rst_scl_filt", bus.scl_filt, 1);
        chk("mid_rst_sda_filt", bus.sda_filt, 1);
        chk("mid_rst_pulses",   {bus.start_p, bus.stop_p, bus.ack_p, bus.nack_p, bus.tmo_p}, 0);
        cyc(2);
        bus.scl_in = 1; bus.sda_in = 0;
        s0 = n_start; k0 = n_stop;
        rst_n = 1;
        cyc(20);
        chk("no_false_start", n_start - s0, 0);
        bus.sda_in = 1; cyc(12);
        chk("no_stop_after_rst", n_stop - k0, 0);
        chk("idle_after_rst", bus.bus_busy, 0);

        // Random pad/agent activity, checked by the per-cycle comparison.
        for (int it = 0; it < 500; it++) begin
            bus.scl_in  = ($urandom_range(0, 3) != 0);
            bus.sda_in  = ($urandom_range(0, 2) != 0);
            bus.scl_drv = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            bus.sda_drv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            bus.arb_en  = N'($urandom);
            bus.arb_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 0; cyc(2); rst_n = 1;
            end
            cyc($urandom_range(1, 10));
        end
        bus.scl_drv = '0; bus.sda_drv = '0; bus.arb_clr = 0;
        bus.scl_in = 1; bus.sda_in = 1;
        cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kei_i2c_bus_resolver.md
KEI_I2C_BUS_RESOLVER -- requirements
Module: kei_i2c_bus_resolver

Interface
REQ-001 Parameter N_AGENTS, default 2: number of on-chip open-drain agents sharing SCL/SDA; legal range 1..8.
REQ-002 Parameter FILT_CYC, default 3: glitch-filter stability length in CLK cycles; legal range 1..15.
REQ-003 Parameter TMO_CYC, default 1024: SCL-low timeout length in CLK cycles; legal range 2..65535.
REQ-004 CLK  in  1  block clock; all sequential logic on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 scl_drv  in  N_AGENTS  bit i = 1: agent i pulls SCL low.
REQ-007 sda_drv  in  N_AGENTS  bit i = 1: agent i pulls SDA low.
REQ-008 arb_en  in  N_AGENTS  bit i = 1: agent i is currently a transmitter and subject to arbitration checking.
REQ-009 scl_in, sda_in  in  1 each  external pad level; 1 = released/pulled up.
REQ-010 arb_clr  in  1  synchronous clear of all arb_lost bits.
REQ-011 scl_line, sda_line  out  1 each  combinational wired-AND: pad level AND NOT(OR of agent drives).
REQ-012 scl_filt, sda_filt  out  1 each  synchronised, glitch-filtered line levels.
REQ-013 start_p, rstart_p, stop_p  out  1 each  single-cycle event pulses.
REQ-014 bus_busy  out  1  1 between START and STOP.
REQ-015 bit_cnt  out  4  SCL rising-edge count within the current byte, 0..8.
REQ-016 ack_p, nack_p  out  1 each  single-cycle 9th-bit result pulses.
REQ-017 arb_lost  out  N_AGENTS  sticky per-agent arbitration-loss flags.
REQ-018 tmo_p  out  1  single-cycle SCL-low timeout pulse.

Function
REQ-019 scl_line/sda_line have zero latency; they are the only combinational outputs.
REQ-020 Each line passes a 2-flop synchroniser, then a filter: filt output changes only after the synchronised value differs from filt for FILT_CYC consecutive cycles; any return to equality resets the stability counter.
REQ-021 Line-to-filt latency is exactly 2 + FILT_CYC cycles; pulses shorter than FILT_CYC cycles never reach filt.
REQ-022 Bus FSM states IDLE and BUSY; event pulses are registered and assert the cycle after the filtered edge.
REQ-023 sda_filt falling while scl_filt = 1: in IDLE, start_p and transition to BUSY; in BUSY, rstart_p and stay in BUSY.
REQ-024 sda_filt rising while scl_filt = 1, in BUSY: stop_p, transition to IDLE; in IDLE it is ignored.
REQ-025 Simultaneous filtered SCL and SDA edges in the same cycle: the SDA condition is evaluated against the previous scl_filt value.
REQ-026 bit_cnt increments on each scl_filt rising edge in BUSY; on the edge where bit_cnt = 8, sample sda_filt (0 -> ack_p, 1 -> nack_p) and wrap to 0.
REQ-027 bit_cnt clears to 0 on START, repeated START and STOP, and holds 0 in IDLE.
REQ-028 Arbitration: on an scl_filt rising edge in BUSY with bit_cnt < 8, set arb_lost[i] if arb_en[i] = 1, sda_drv[i] = 0 and sda_filt = 0.
REQ-029 arb_lost bits are sticky, cleared by arb_clr or stop_p; a set condition and arb_clr in the same cycle leaves the bit set.
REQ-030 Timeout counter counts cycles with scl_filt = 0 in BUSY and clears when scl_filt = 1 or in IDLE.
REQ-031 When the counter reaches TMO_CYC: tmo_p pulses once, then the counter saturates (no further pulse) until cleared; bus_busy is unaffected.

Reset
REQ-032 On RST_N low: synchronisers and filters reset to 1; FSM to IDLE; bit_cnt, counters, arb_lost and all pulses reset to 0; bus_busy = 0.
REQ-033 Deassertion mid-transfer leaves FSM in IDLE until the next valid START; no false start_p is produced from reset-value lines.

Structure
REQ-034 Shared package kei_i2c_pkg holds the FSM state enum, the bit-count width constant and the default parameter constants.
REQ-035 One sub-module kei_i2c_line_filter (synchroniser plus filter, FILT_CYC parameter), instantiated once for SCL and once for SDA.

Verification
REQ-036 FILT_CYC=3: pad SDA falls with SCL high -> start_p exactly 6 cycles later, bus_busy = 1.
REQ-037 SDA low glitch of 2 cycles with SCL high -> no start_p, sda_filt stays 1.
REQ-038 Byte 0xA5 plus SDA=0 on the 9th clock -> bit_cnt counts 1..8, ack_p once, bit_cnt = 0; repeated with SDA=1 -> nack_p.
REQ-039 N_AGENTS=2, arb_en=2'b11, bit 3: agent0 releases SDA, agent1 drives low -> arb_lost = 2'b01, cleared at STOP.
REQ-040 TMO_CYC=16, SCL held low 40 cycles in BUSY -> exactly one tmo_p at cycle 16 of the low period.
REQ-041 RST_N asserted mid-byte -> all outputs at reset values immediately; STOP afterwards -> no stop_p.
